// File: rtl/hams_merge_accumulate.sv
// rtl/hams_merge_accumulate.sv - merge-sorter drain stage: sums adjacent equal keys, emits one {key,sum} per unique key
//
// Ports:
//   clk, rst           single rising-edge clock, asynchronous active-high reset
//   start, total_cnt   begin a stream of total_cnt elements (accepted in IDLE only)
//   fifo_empty         FWFT FIFO empty; fifo_data is the head word {key,val}
//   fifo_pop           pop the FIFO head this cycle (combinational)
//   out_vld/out_rdy    output handshake; out_key/out_val/out_last carry the word
//   busy               FSM not IDLE
//   done               one-cycle pulse once the final word has been accepted
//   uniq_cnt           unique keys emitted in the current/last stream
//   order_err          (HAMS_ORDER_CHECK_EN only) sticky until next start;
//                      set when a popped key is smaller than the held key
//
// Build option: define HAMS_ORDER_CHECK_EN to add the order_err output.

module hams_merge_accumulate #(
    parameter int KEY_W = 16,
    parameter int VAL_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       total_cnt,
    input  logic                   fifo_empty,
    input  logic [KEY_W+VAL_W-1:0] fifo_data,
    output logic                   fifo_pop,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [KEY_W-1:0]       out_key,
    output logic [VAL_W-1:0]       out_val,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       uniq_cnt
`ifdef HAMS_ORDER_CHECK_EN
    ,
    output logic                   order_err
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FIRST = 3'd1;
    localparam logic [2:0] S_ACCUM = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state;
    logic [KEY_W-1:0] hold_key;
    logic [VAL_W-1:0] hold_val;
    logic [CNT_W-1:0] remaining;

    logic [KEY_W-1:0] head_key;
    logic [VAL_W-1:0] head_val;
    logic             key_eq;
    logic             out_free;
    logic             rem_last;

    assign head_key = fifo_data[KEY_W+VAL_W-1:VAL_W];
    assign head_val = fifo_data[VAL_W-1:0];
    assign key_eq   = (head_key == hold_key);
    // Output register can take a new word this cycle: empty, or being drained now.
    assign out_free = !out_vld || out_rdy;
    assign rem_last = (remaining == CNT_W'(1));
    assign busy     = (state != S_IDLE);

    // An equal key only touches the hold register, so it may be popped even while
    // the output register is stalled; a new key needs the output register free.
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            S_FIRST: fifo_pop = !fifo_empty;
            S_ACCUM: fifo_pop = !fifo_empty && (remaining != '0) && (key_eq || out_free);
            default: fifo_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            hold_key  <= '0;
            hold_val  <= '0;
            remaining <= '0;
            out_vld   <= 1'b0;
            out_key   <= '0;
            out_val   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            uniq_cnt  <= '0;
`ifdef HAMS_ORDER_CHECK_EN
            order_err <= 1'b0;
`endif
        end else begin
            done <= 1'b0;

            // Accepted word leaves; any reload below in the same cycle overrides this.
            if (out_vld && out_rdy) begin
                out_vld  <= 1'b0;
                out_last <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= total_cnt;
                        uniq_cnt  <= '0;
`ifdef HAMS_ORDER_CHECK_EN
                        order_err <= 1'b0;
`endif
                        state     <= (total_cnt == '0) ? S_DONE : S_FIRST;
                    end
                end

                S_FIRST: begin
                    if (fifo_pop) begin
                        hold_key  <= head_key;
                        hold_val  <= head_val;
                        remaining <= remaining - CNT_W'(1);
                        state     <= rem_last ? S_FLUSH : S_ACCUM;
                    end
                end

                S_ACCUM: begin
                    if (fifo_pop) begin
                        if (key_eq) begin
                            hold_val <= hold_val + head_val;
                        end else begin
                            out_key  <= hold_key;
                            out_val  <= hold_val;
                            out_vld  <= 1'b1;
                            uniq_cnt <= uniq_cnt + CNT_W'(1);
                            hold_key <= head_key;
                            hold_val <= head_val;
`ifdef HAMS_ORDER_CHECK_EN
                            if (head_key < hold_key)
                                order_err <= 1'b1;
`endif
                        end
                        remaining <= remaining - CNT_W'(1);
                        if (rem_last)
                            state <= S_FLUSH;
                    end
                end

                S_FLUSH: begin
                    if (out_free) begin
                        out_key  <= hold_key;
                        out_val  <= hold_val;
                        out_vld  <= 1'b1;
                        out_last <= 1'b1;
                        uniq_cnt <= uniq_cnt + CNT_W'(1);
                        state    <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (out_free) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hams_merge_accumulate.sv
// tb/tb_hams_merge_accumulate.sv - directed vector bench for hams_merge_accumulate

module tb_hams_merge_accumulate;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] total_cnt;
    logic        fifo_empty;
    logic [47:0] fifo_data;
    logic        fifo_pop;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] out_key;
    logic [31:0] out_val;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [15:0] uniq_cnt;
`ifdef HAMS_ORDER_CHECK_EN
    logic        order_err;
`endif

    hams_merge_accumulate dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .total_cnt (total_cnt),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_pop  (fifo_pop),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_key   (out_key),
        .out_val   (out_val),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .uniq_cnt  (uniq_cnt)
`ifdef HAMS_ORDER_CHECK_EN
        ,
        .order_err (order_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]        n;
        logic [0:7][15:0]  k;
        logic [0:7][31:0]  v;
        logic [3:0]        ne;
        logic [0:3][15:0]  ek;
        logic [0:3][31:0]  ev;
        logic              bp;
    } vec_t;

    vec_t        tbl[7];
    int          nvec;
    int          nerr;
    logic [47:0] q[$];
    logic [48:0] got[$];
    int          done_cnt;
    int          vld_cnt;
    int          pop_seen;
    logic        pop_req;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FWFT FIFO model: pop decided from the settled fifo_pop at the falling edge,
    // applied just after the rising edge the DUT used it on.
    initial begin
        logic [47:0] tmp;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        pop_req    = 1'b0;
        forever begin
            @(negedge clk);
            pop_req = fifo_pop;
            @(posedge clk);
            #1;
            if (pop_req && q.size() > 0) tmp = q.pop_front();
            fifo_empty = (q.size() == 0);
            fifo_data  = fifo_empty ? 48'd0 : q[0];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (out_vld && out_rdy) got.push_back({out_last, out_key, out_val});
            if (done)     done_cnt++;
            if (out_vld)  vld_cnt++;
            if (fifo_pop) pop_seen++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int cyc;
        q.delete();
        for (int j = 0; j < int'(v.n); j++) q.push_back({v.k[j], v.v[j]});
        got.delete();
        done_cnt = 0;
        step();
        total_cnt = 16'(v.n);
        start     = 1'b1;
        step();
        start = 1'b0;
        cyc   = 0;
        while (done_cnt == 0 && cyc < 200) begin
            out_rdy = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            cyc++;
        end
        out_rdy = 1'b1;
        repeat (3) step();
        chk($sformatf("v%0d done_pulses", id), done_cnt, 1);
        chk($sformatf("v%0d word_count", id), got.size(), v.ne);
        for (int j = 0; j < int'(v.ne); j++) begin
            if (j < got.size()) begin
                chk($sformatf("v%0d w%0d key", id, j), got[j][47:32], v.ek[j]);
                chk($sformatf("v%0d w%0d val", id, j), got[j][31:0], v.ev[j]);
                chk($sformatf("v%0d w%0d last", id, j), got[j][48], (j == int'(v.ne) - 1));
            end
        end
        chk($sformatf("v%0d uniq_cnt", id), uniq_cnt, v.ne);
        chk($sformatf("v%0d busy", id), busy, 0);
        chk($sformatf("v%0d fifo_drained", id), q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " fifo_pop"}, fifo_pop, 0);
        chk({tag, " out_vld"}, out_vld, 0);
        chk({tag, " out_key"}, out_key, 0);
        chk({tag, " out_val"}, out_val, 0);
        chk({tag, " out_last"}, out_last, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " uniq_cnt"}, uniq_cnt, 0);
    endtask

    initial begin
        vec_t v;
        int   cyc;
        nvec = 0; nerr = 0;
        done_cnt = 0; vld_cnt = 0; pop_seen = 0;
        rst = 1'b1; start = 1'b0; total_cnt = '0; out_rdy = 1'b1;

        tbl[0] = '0; tbl[0].n = 5; tbl[0].ne = 3;
        tbl[0].k  = {16'd1, 16'd1, 16'd2, 16'd3, 16'd3, 16'd0, 16'd0, 16'd0};
        tbl[0].v  = {32'd10, 32'd20, 32'd5, 32'd7, 32'd1, 32'd0, 32'd0, 32'd0};
        tbl[0].ek = {16'd1, 16'd2, 16'd3, 16'd0};
        tbl[0].ev = {32'd30, 32'd5, 32'd8, 32'd0};

        tbl[1] = '0;

        tbl[2] = '0; tbl[2].n = 4; tbl[2].ne = 1;
        tbl[2].k  = {16'd7, 16'd7, 16'd7, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0};
        tbl[2].v  = {32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[2].ek = {16'd7, 16'd0, 16'd0, 16'd0};
        tbl[2].ev = {32'd5, 32'd0, 32'd0, 32'd0};

        tbl[3] = '0; tbl[3].n = 1; tbl[3].ne = 1;
        tbl[3].k  = {16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        tbl[3].v  = {32'd42, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[3].ek = {16'd9, 16'd0, 16'd0, 16'd0};
        tbl[3].ev = {32'd42, 32'd0, 32'd0, 32'd0};

        tbl[4] = '0; tbl[4].n = 4; tbl[4].ne = 4; tbl[4].bp = 1'b1;
        tbl[4].k  = {16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
        tbl[4].v  = {32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[4].ek = {16'd1, 16'd2, 16'd3, 16'd4};
        tbl[4].ev = {32'd1, 32'd2, 32'd3, 32'd4};

        tbl[5] = '0; tbl[5].n = 4; tbl[5].ne = 2; tbl[5].bp = 1'b1;
        tbl[5].k  = {16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0};
        tbl[5].v  = {32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[5].ek = {16'h0000, 16'hFFFF, 16'd0, 16'd0};
        tbl[5].ev = {32'd3, 32'd7, 32'd0, 32'd0};

        tbl[6] = '0; tbl[6].n = 8; tbl[6].ne = 3; tbl[6].bp = 1'b1;
        tbl[6].k  = {16'd2, 16'd2, 16'd2, 16'd5, 16'd5, 16'd9, 16'd9, 16'd9};
        tbl[6].v  = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        tbl[6].ek = {16'd2, 16'd5, 16'd9, 16'd0};
        tbl[6].ev = {32'd6, 32'd9, 32'd21, 32'd0};

        repeat (2) step();
        chk_zero("reset");
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

        // total_cnt == 0: done exactly two cycles after start, nothing popped or emitted
        vld_cnt = 0; pop_seen = 0;
        total_cnt = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero done_early", done, 0);
        chk("zero busy", busy, 1);
        step();
        chk("zero done_pulse", done, 1);
        step();
        chk("zero done_drop", done, 0);
        chk("zero busy_end", busy, 0);
        chk("zero out_vld_cycles", vld_cnt, 0);
        chk("zero pop_cycles", pop_seen, 0);

        // Backpressure: hold and output regs fill, popping stops, output stays put
        q.delete(); got.delete(); done_cnt = 0;
        for (int j = 0; j < 4; j++) q.push_back({16'(j + 1), 32'(100 + j)});
        out_rdy = 1'b0;
        step();
        pop_seen = 0;
        total_cnt = 16'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("bp out_key_early", out_key, 1);
        repeat (7) step();
        chk("bp pops_stalled", pop_seen, 2);
        chk("bp out_vld", out_vld, 1);
        chk("bp out_key", out_key, 1);
        chk("bp out_val", out_val, 100);
        out_rdy = 1'b1;
        cyc = 0;
        while (done_cnt == 0 && cyc < 50) begin
            step();
            cyc++;
        end
        chk("bp done", done_cnt, 1);
        chk("bp words", got.size(), 4);
        for (int j = 0; j < 4; j++) begin
            if (j < got.size()) begin
                chk($sformatf("bp w%0d key", j), got[j][47:32], j + 1);
                chk($sformatf("bp w%0d val", j), got[j][31:0], 100 + j);
                chk($sformatf("bp w%0d last", j), got[j][48], (j == 3));
            end
        end
        chk("bp uniq_cnt", uniq_cnt, 4);

        // Reset in the middle of a stream, then a clean new stream
        q.delete();
        for (int j = 0; j < 8; j++) q.push_back({16'(j + 1), 32'(j)});
        step();
        pop_seen = 0;
        total_cnt = 16'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (pop_seen < 3 && cyc < 50) begin
            step();
            cyc++;
        end
        chk("rst reached_three_pops", pop_seen >= 3, 1);
        chk("rst busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        q.delete();
        step();
        rst = 1'b0;
        v = '0; v.n = 2; v.ne = 1;
        v.k  = {16'd3, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        v.v  = {32'd4, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        v.ek = {16'd3, 16'd0, 16'd0, 16'd0};
        v.ev = {32'd10, 32'd0, 32'd0, 32'd0};
        run_vec(v, 10);

`ifdef HAMS_ORDER_CHECK_EN
        v = '0; v.n = 2; v.ne = 2;
        v.k  = {16'd5, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        v.v  = {32'd11, 32'd22, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        v.ek = {16'd5, 16'd3, 16'd0, 16'd0};
        v.ev = {32'd11, 32'd22, 32'd0, 32'd0};
        run_vec(v, 11);
        chk("order_err set", order_err, 1);
        run_vec(tbl[3], 12);
        chk("order_err cleared", order_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
